dcache_module: RTL and testbench
================================

// Module: dcache_module
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between mem_unit_module and data memory.
//  Drives MEM_BUSYWAIT, which stalls the whole pipeline through the pipeline registers and the IF unit.
//  Returns load data to the MEM stage and moves 128-bit blocks to and from main memory.
// PARAMETERS
//  INDEX_BITS  3  log2(number of lines); default 8 lines; tag = 28-INDEX_BITS bits
// PORTS
//  CLK              in   1    rising-edge clock
//  RESET            in   1    asynchronous, active-low reset
//  READ             in   1    CPU load request
//  WRITE            in   1    CPU store request
//  ADDRESS          in   32   CPU byte address; [1:0] ignored; word=[3:2]; index=[3+INDEX_BITS:4]; tag=[31:4+INDEX_BITS]
//  WRITEDATA        in   32   store data, already lane-aligned
//  BYTE_EN          in   4    store byte lanes (SB/SH/SW encoded upstream)
//  READDATA         out  32   load data, full word
//  BUSYWAIT         out  1    CPU stall, drives MEM_BUSYWAIT
//  MEM_READ         out  1    memory block read strobe
//  MEM_WRITE        out  1    memory block write strobe
//  MEM_ADDRESS      out  28   memory block address (ADDRESS[31:4])
//  MEM_WRITEDATA    out  128  victim block, word0 in [31:0]
//  MEM_READDATA     in   128  fetched block, word0 in [31:0]
//  MEM_BUSYWAIT_IN  in   1    memory busy; transfer completes on the first cycle it is low while a strobe is high
// BEHAVIOUR
//  Storage: per line valid, dirty, tag, 128-bit data. Reset clears all valid and dirty bits; data is not reset.
//  hit = valid[index] & (tag[index]==ADDRESS tag). req = READ|WRITE.
//  READDATA is combinational: data[index] word [3:2]. Valid only while hit & state==IDLE. Reset value: 0 while no line valid.
//  BUSYWAIT is combinational: (req & !hit) | (state!=IDLE). Reset value 0. It rises in the same cycle as a miss.
//  Read hit: zero-cycle latency, no stall.
//  Write hit: no stall. The selected bytes are written at the next posedge and dirty is set.
//    The write happens only in IDLE; stores during a stall are not written until the post-fill hit.
//  READ and WRITE together: treated as a write.
//  FSM:
//   IDLE:      req & !hit & dirty[index] -> WRITEBACK
//              req & !hit & !dirty       -> ALLOCATE
//              otherwise stay IDLE
//   WRITEBACK: MEM_WRITE=1; MEM_ADDRESS={tag[index],index}; MEM_WRITEDATA=data[index]
//              -> ALLOCATE when !MEM_BUSYWAIT_IN
//   ALLOCATE:  MEM_READ=1; MEM_ADDRESS=ADDRESS[31:4]
//              -> UPDATE when !MEM_BUSYWAIT_IN
//   UPDATE:    one cycle, strobes low; at posedge data<=MEM_READDATA (registered on the ALLOCATE exit edge),
//              tag<=ADDRESS tag, valid<=1, dirty<=0 -> IDLE
//  Back in IDLE the request now hits. Read miss stall = writeback + fill + 2 cycles.
//  Strobes are never high together. MEM_ADDRESS/MEM_WRITEDATA are 0 when both strobes are low.
//  The CPU holds ADDRESS, WRITEDATA, BYTE_EN and the request stable while BUSYWAIT=1 (the pipeline is frozen).
//  req dropping mid-miss: the FSM still completes the fill to IDLE; the line stays valid.
//  RESET low at any time: state->IDLE, strobes and BUSYWAIT low immediately, all valid/dirty cleared.
//    Any in-flight memory transfer is abandoned.
//  Index wrap: lines are independent; 2^INDEX_BITS blocks apart alias to the same line (conflict miss).
// TESTING
//  1 Cold read 0x0000_0104, memory 1-cycle busy -> BUSYWAIT high same cycle, MEM_READ with MEM_ADDRESS=0x0000010, no MEM_WRITE, hit after UPDATE, READDATA=word1 of block
//  2 Read 0x0000_0108 next -> hit, BUSYWAIT=0, READDATA=word2, no memory strobes
//  3 SB 0xAB to 0x0000_0105 (BYTE_EN=0010) on the hit line -> no stall; a later read of 0x104 returns word1 with [15:8]=0xAB; dirty=1
//  4 Read 0x0000_0184 (same index, new tag) -> MEM_WRITE of dirty block to 0x0000010 first, then MEM_READ 0x0000018, then hit
//  5 RESET pulsed low in ALLOCATE -> BUSYWAIT/MEM_READ drop asynchronously; after release, read 0x104 misses again
//  6 READ=WRITE=1 on a hit -> write performed, dirty set, no stall

Source files
------------

// File: rtl/dcache_module.sv
// Direct-mapped, write-back, write-allocate data cache sitting between the MEM stage and data memory.
// Hits complete with no stall; a miss stalls the pipeline through optional writeback, fill and update.
module dcache_module #(
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         READ,
    input  logic         WRITE,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    input  logic [3:0]   BYTE_EN,
    output logic [31:0]  READDATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT_IN
);

    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 28 - INDEX_BITS;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WRITEBACK = 2'd1;
    localparam logic [1:0] S_ALLOCATE  = 2'd2;
    localparam logic [1:0] S_UPDATE    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [TAG_W-1:0] tag_d  [LINES];
    logic [127:0]     data_q [LINES];
    logic [127:0]     data_d [LINES];
    logic [127:0]     fill_q, fill_d;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      addr_tag;
    logic [1:0]            word;
    logic                  hit;
    logic                  req;
    logic                  unused_addr_bits;

    assign idx              = ADDRESS[3+INDEX_BITS:4];
    assign addr_tag         = ADDRESS[31:4+INDEX_BITS];
    assign word             = ADDRESS[3:2];
    assign hit              = valid_q[idx] && (tag_q[idx] == addr_tag);
    assign req              = READ || WRITE;
    assign unused_addr_bits = &{1'b0, ADDRESS[1:0]};

    // Load data is only meaningful on an idle hit; zero otherwise keeps it defined out of reset.
    assign READDATA = (hit && state_q == S_IDLE) ? data_q[idx][{word, 5'd0} +: 32] : 32'd0;
    assign BUSYWAIT = RESET && ((req && !hit) || (state_q != S_IDLE));

    // Next-state, line update and memory strobes.
    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        tag_d         = tag_q;
        data_d        = data_q;
        fill_d        = fill_q;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = 28'd0;
        MEM_WRITEDATA = 128'd0;
        case (state_q)
            S_IDLE: begin
                if (req && !hit) begin
                    state_d = dirty_q[idx] ? S_WRITEBACK : S_ALLOCATE;
                end else if (WRITE && hit) begin
                    for (int b = 0; b < 4; b++) begin
                        if (BYTE_EN[b]) begin
                            data_d[idx][{word, 5'd0} + 7'(8 * b) +: 8] = WRITEDATA[8*b +: 8];
                        end
                    end
                    dirty_d[idx] = 1'b1;
                end
            end
            S_WRITEBACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_q[idx], idx};
                MEM_WRITEDATA = data_q[idx];
                if (!MEM_BUSYWAIT_IN) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[31:4];
                if (!MEM_BUSYWAIT_IN) begin
                    fill_d  = MEM_READDATA;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                data_d[idx]  = fill_q;
                tag_d[idx]   = addr_tag;
                valid_d[idx] = 1'b1;
                dirty_d[idx] = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tags and data are qualified by valid, so they carry no reset.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
        fill_q <= fill_d;
    end

endmodule

// File: tb/tb_dcache_module.sv
// Bench for dcache_module: behavioural memory with fixed latency, reference cache model,
// scoreboard of expected memory transfers, table of CPU operations plus a mid-fill reset.
module tb_dcache_module;

    localparam int LAT = 1;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         READ;
    logic         WRITE;
    logic [31:0]  ADDRESS;
    logic [31:0]  WRITEDATA;
    logic [3:0]   BYTE_EN;
    logic [31:0]  READDATA;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT_IN;

    typedef struct {
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } xfer_t;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        int          stall;
    } vec_t;

    logic [127:0] mem   [256];
    logic [127:0] model [256];
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [24:0]  m_tag   [8];
    xfer_t        exp_q [$];
    vec_t         vecs  [$];
    int           cnt = 0;
    int           checks = 0;
    int           failures = 0;

    dcache_module #(.INDEX_BITS(3)) dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
        .WRITEDATA(WRITEDATA), .BYTE_EN(BYTE_EN), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT_IN(MEM_BUSYWAIT_IN)
    );

    always #5 CLK = ~CLK;

    assign MEM_BUSYWAIT_IN = (MEM_READ || MEM_WRITE) && (cnt < LAT);
    assign MEM_READDATA    = mem[MEM_ADDRESS[7:0]];

    function automatic logic [31:0] init_word(int b, int w);
        return {20'(b), 4'hA, 6'd0, 2'(w)};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: score a completing memory transfer, advance, then apply memory-side effects.
    task automatic tick();
        int           cnt_n;
        bit           wr_done;
        logic [7:0]   wa;
        logic [127:0] wd;
        xfer_t        e;
        cnt_n   = 0;
        wr_done = 0;
        wa      = '0;
        wd      = '0;
        check("strobe_exclusive", 128'(MEM_READ && MEM_WRITE), 128'd0);
        if (RESET && (MEM_READ || MEM_WRITE)) begin
            if (!MEM_BUSYWAIT_IN) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mem_xfer_unexpected actual=wr%0b@%0h required=none", MEM_WRITE, MEM_ADDRESS);
                end else begin
                    e = exp_q.pop_front();
                    check("mem_xfer_kind", 128'(MEM_WRITE), 128'(e.wr));
                    check("mem_xfer_addr", 128'(MEM_ADDRESS), 128'(e.addr));
                    if (e.wr) check("mem_xfer_wdata", MEM_WRITEDATA, e.data);
                end
                if (MEM_WRITE) begin
                    wr_done = 1;
                    wa      = MEM_ADDRESS[7:0];
                    wd      = MEM_WRITEDATA;
                end
            end else begin
                cnt_n = cnt + 1;
            end
        end
        @(posedge CLK);
        #1;
        cnt = cnt_n;
        if (wr_done) mem[wa] = wd;
        @(negedge CLK);
    endtask

    // Drive one CPU access, predict its transfers and stall, then check result and update the model.
    task automatic do_op(vec_t v, int n_op);
        logic [2:0]  idx;
        logic [24:0] tg;
        logic [27:0] blk;
        logic [27:0] vb;
        bit          miss;
        int          n;
        int          w;
        idx  = v.addr[6:4];
        tg   = v.addr[31:7];
        blk  = v.addr[31:4];
        w    = int'(v.addr[3:2]);
        miss = !(m_valid[idx] && m_tag[idx] == tg);
        vb   = {m_tag[idx], idx};
        if (miss && m_dirty[idx]) exp_q.push_back('{1'b1, vb, model[vb[7:0]]});
        if (miss) exp_q.push_back('{1'b0, blk, 128'd0});
        READ      = v.rd;
        WRITE     = v.wr;
        ADDRESS   = v.addr;
        WRITEDATA = v.wd;
        BYTE_EN   = v.be;
        #1;
        check($sformatf("op%0d_busy_same_cycle", n_op), 128'(BUSYWAIT), 128'(miss));
        n = 0;
        while (BUSYWAIT && n < 40) begin
            tick();
            n++;
        end
        check($sformatf("op%0d_stall_cycles", n_op), 128'(n), 128'(v.stall));
        check($sformatf("op%0d_busy_released", n_op), 128'(BUSYWAIT), 128'd0);
        check($sformatf("op%0d_mem_idle", n_op),
              {MEM_WRITEDATA ^ 128'(MEM_ADDRESS)} | 128'(MEM_READ || MEM_WRITE), 128'd0);
        if (v.rd && !v.wr) begin
            check($sformatf("op%0d_readdata", n_op), 128'(READDATA), 128'(model[blk[7:0]][32*w +: 32]));
        end
        tick();
        if (v.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (v.be[b]) model[blk[7:0]][32*w + 8*b +: 8] = v.wd[8*b +: 8];
            end
        end
        m_dirty[idx] = (miss ? 1'b0 : m_dirty[idx]) | v.wr;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        for (int i = 0; i < 256; i++) model[i] = mem[i];
    endtask

    initial begin
        vec_t v;
        for (int b = 0; b < 256; b++) begin
            mem[b] = {init_word(b, 3), init_word(b, 2), init_word(b, 1), init_word(b, 0)};
        end
        model_reset();
        for (int i = 0; i < 8; i++) m_tag[i] = '0;

        vecs.push_back('{1, 0, 32'h0000_0104, 32'h0,          4'h0, 4}); // cold read miss
        vecs.push_back('{1, 0, 32'h0000_0108, 32'h0,          4'h0, 0}); // read hit word2
        vecs.push_back('{0, 1, 32'h0000_0105, 32'h0000_AB00,  4'h2, 0}); // SB on hit
        vecs.push_back('{1, 0, 32'h0000_0104, 32'h0,          4'h0, 0}); // sees stored byte
        vecs.push_back('{1, 0, 32'h0000_0184, 32'h0,          4'h0, 6}); // dirty conflict miss
        vecs.push_back('{1, 0, 32'h0000_0104, 32'h0,          4'h0, 4}); // refetch written-back block
        vecs.push_back('{0, 1, 32'h0000_2008, 32'hDEAD_BEEF,  4'hF, 4}); // write miss allocate
        vecs.push_back('{1, 1, 32'h0000_2008, 32'h1122_3344,  4'hC, 0}); // READ+WRITE is a store
        vecs.push_back('{1, 0, 32'h0000_2008, 32'h0,          4'h0, 0});
        vecs.push_back('{1, 0, 32'h0000_2088, 32'h0,          4'h0, 6}); // alias on index 0
        vecs.push_back('{0, 1, 32'h0000_01F4, 32'hCAFE_F00D,  4'hF, 4}); // last index
        vecs.push_back('{1, 0, 32'h0000_01F4, 32'h0,          4'h0, 0});

        RESET     = 1'b0;
        READ      = 1'b0;
        WRITE     = 1'b0;
        ADDRESS   = 32'h0000_0104;
        WRITEDATA = 32'h0;
        BYTE_EN   = 4'h0;
        @(negedge CLK);
        tick();
        check("reset_busywait", 128'(BUSYWAIT), 128'd0);
        check("reset_readdata", 128'(READDATA), 128'd0);
        check("reset_strobes", 128'({MEM_READ, MEM_WRITE}), 128'd0);
        RESET = 1'b1;
        tick();
        check("idle_readdata_invalid", 128'(READDATA), 128'd0);

        for (int i = 0; i < vecs.size(); i++) do_op(vecs[i], i);

        // Reset while a fill is in flight: strobes and stall drop at once, lines invalidated.
        READ    = 1'b1;
        ADDRESS = 32'h0000_0304;
        #1;
        check("rst_seq_busy_on_miss", 128'(BUSYWAIT), 128'd1);
        tick();
        check("rst_seq_in_allocate", 128'({MEM_READ, MEM_WRITE}), 128'b10);
        check("rst_seq_alloc_addr", 128'(MEM_ADDRESS), 128'h30);
        RESET = 1'b0;
        #1;
        check("rst_seq_busy_drop", 128'(BUSYWAIT), 128'd0);
        check("rst_seq_mem_read_drop", 128'(MEM_READ), 128'd0);
        tick();
        READ = 1'b0;
        tick();
        RESET = 1'b1;
        model_reset();
        tick();

        v = '{1, 0, 32'h0000_0104, 32'h0, 4'h0, 4};
        do_op(v, 100);
        v = '{1, 0, 32'h0000_01F4, 32'h0, 4'h0, 4};
        do_op(v, 101);

        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
